// File: rtl/gpu_mem_arbiter.sv
// rtl/gpu_mem_arbiter.sv - round-robin arbiter with a high-priority class, one transaction in flight
// Optional transaction watchdog: define GPU_ARB_TIMEOUT_EN.
module gpu_mem_arbiter #(
  parameter int NUM_REQ        = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int ID_W          = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  req_we,
  input  logic [ADDR_W-1:0]   req_addr  [NUM_REQ],
  input  logic [DATA_W-1:0]   req_wdata [NUM_REQ],
  input  logic [NUM_REQ-1:0]  hi_prio,
  output logic [NUM_REQ-1:0]  ack,
  output logic [NUM_REQ-1:0]  err,
  output logic [DATA_W-1:0]   rdata     [NUM_REQ],
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic                busy_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q [NUM_REQ];

  logic [NUM_REQ-1:0]  cand;
  logic [ID_W-1:0]     win_d;
  logic                found;

  // High-priority requesters mask everyone else; scan starts at the rotating pointer.
  always_comb begin
    cand  = (|(req & hi_prio)) ? (req & hi_prio) : req;
    win_d = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

`ifdef GPU_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  err_q;
`else
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
`ifdef GPU_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef GPU_ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            grant_q     <= win_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we[win_d];
            mem_addr_q  <= req_addr[win_d];
            mem_wdata_q <= req_wdata[win_d];
            busy_q      <= 1'b1;
            state_q     <= S_BUSY;
`ifdef GPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            mem_req_q        <= 1'b0;
            rdata_q[grant_q] <= mem_rdata;
            ack_q[grant_q]   <= 1'b1;
            state_q          <= S_RESP;
          end
`ifdef GPU_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q        <= 1'b0;
            rdata_q[grant_q] <= '0;
            ack_q[grant_q]   <= 1'b1;
            err_q[grant_q]   <= 1'b1;
            state_q          <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          ptr_q   <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GPU_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = '0;
`endif

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
